// File: rtl/rs232_tx_fifo.sv
// -----------------------------------------------------------------------------
// rs232_tx_fifo
//
// Stand-alone 8N1 RS232 transmitter fronted by a small circular FIFO. Fabric
// logic pushes bytes on a valid/ready stream, and the transmitter serialises
// them LSB-first at CLK_HZ/BAUD clocks per bit. Queued bytes go out as
// contiguous frames, with no idle gap between a stop bit and the next start bit.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate; DIVISOR = CLK_HZ/BAUD (truncated) must be >= 2
//   FIFO_DEPTH  input FIFO entries; a power of two, >= 2
//   STOP_BITS   1 or 2
//
// Ports:
//   clk_clk        system clock; all logic runs on the rising edge
//   reset_reset_n  asynchronous active-low reset
//   tx_data        byte to send
//   tx_valid       tx_data is valid; a byte is accepted when tx_ready is also high
//   tx_ready       FIFO has room (combinational, level != FIFO_DEPTH)
//   txd            serial line, idle high, registered
//   busy           registered; high while a frame is in progress or bytes are queued
//   fifo_level     current FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module rs232_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_W   = $clog2(DIVISOR);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    // Transmitter state
    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic baud_done;
    logic stop_final;

    assign fifo_nonempty = (level != '0);
    assign tx_ready      = (level != FULL_LEVEL);
    assign fifo_level    = level;

    assign push       = tx_valid && tx_ready;
    assign baud_done  = (baud_cnt == DIV_LAST);
    assign stop_final = (state == STOP) && baud_done && (bit_idx == STOP_LAST);

    // The head byte is taken either from IDLE or on the last cycle of the
    // final stop bit; the latter is what makes queued frames contiguous.
    assign pop = fifo_nonempty && ((state == IDLE) || stop_final);

    // FIFO data array. It needs no reset: the pointers and level are cleared,
    // so stale contents are never read after a flush.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two. A push and a pop on the same edge both take effect
    // and leave the level unchanged.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Frame sequencer. txd is registered and written on the same edge as each
    // state or bit transition, so every bit lasts exactly DIVISOR cycles. The
    // head byte is copied into shift_reg at the pop, so the frame in flight no
    // longer depends on the FIFO. busy looks at the pre-edge state, so it
    // falls one cycle after STOP hands over to IDLE with nothing queued.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            busy <= (state != IDLE) || fifo_nonempty;

            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        txd       <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        txd       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            txd     <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            txd       <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (pop) begin
                                shift_reg <= mem[rd_ptr];
                                txd       <= 1'b0;
                                state     <= START;
                            end else begin
                                txd   <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    txd      <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants: the occupancy stays in range and the line is
    // high whenever the sequencer sits in IDLE.
    level_in_range: assert property (
        @(posedge clk_clk) disable iff (!reset_reset_n) level <= FULL_LEVEL
    );

    idle_line_high: assert property (
        @(posedge clk_clk) disable iff (!reset_reset_n) (state == IDLE) |-> txd
    );

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_rs232_tx_fifo
//
// Directed bench for rs232_tx_fifo with CLK_HZ=1000 and BAUD=100 (DIVISOR=10).
// dut_a uses one stop bit and dut_b uses two; both share the clock and reset.
// Edge numbers in the tables count from the edge that accepts the first byte.
// A small serial receiver decodes dut_a's line so that byte order can be checked.
// -----------------------------------------------------------------------------
module tb_rs232_tx_fifo;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;

    typedef struct {
        int         e;
        logic       v;
        logic [7:0] d;
        logic       txd;
        logic       busy;
        logic [2:0] lvl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic       a_txd;
    logic       a_busy;
    logic [2:0] a_level;

    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       b_txd;
    logic       b_busy;
    logic [2:0] b_level;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    vec_t       single_vecs[$];
    vec_t       stop2_vecs[$];
    vec_t       cur_vecs[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    rs232_tx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)
    ) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .txd(a_txd), .busy(a_busy), .fifo_level(a_level)
    );

    rs232_tx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)
    ) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .txd(b_txd), .busy(b_busy), .fifo_level(b_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            b_valid = v;
            b_data  = d;
        end else begin
            a_valid = v;
            a_data  = d;
        end
    endtask

    // Advance to #1 after edge number t; the caller is always at that offset.
    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int bound);
        int s;
        s = cyc;
        while (((a_busy !== 1'b0) || (b_busy !== 1'b0)) && (cyc < s + bound)) begin
            @(posedge clk);
            #1;
        end
        checkOutput("idle wait", {31'b0, a_busy | b_busy}, 32'd0);
        wait_until(cyc + 3);
    endtask

    // Hold tx_valid with byte d until an edge accepts it; acc is that edge.
    task automatic push_held(input logic [7:0] d, output int acc);
        logic r;
        acc = -1;
        applyStimulus(1'b0, 1'b1, d);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            r = a_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
        end
    endtask

    task automatic check_rx(input string name);
        checkOutput({name, " rx count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s rx byte %0d", name, i),
                        (i < rx_q.size()) ? {24'b0, rx_q[i]} : 32'hDEADBEEF,
                        {24'b0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic run_table(input bit sel, input string tag);
        int base;
        base = cyc + 1;
        for (int i = 0; i < cur_vecs.size(); i++) begin
            wait_until(base + cur_vecs[i].e - 1);
            applyStimulus(sel, cur_vecs[i].v, cur_vecs[i].d);
            wait_until(base + cur_vecs[i].e);
            applyStimulus(sel, 1'b0, 8'h00);
            checkOutput($sformatf("%s e%0d txd", tag, cur_vecs[i].e),
                        {31'b0, sel ? b_txd : a_txd}, {31'b0, cur_vecs[i].txd});
            checkOutput($sformatf("%s e%0d busy", tag, cur_vecs[i].e),
                        {31'b0, sel ? b_busy : a_busy}, {31'b0, cur_vecs[i].busy});
            checkOutput($sformatf("%s e%0d level", tag, cur_vecs[i].e),
                        {29'b0, sel ? b_level : a_level}, {29'b0, cur_vecs[i].lvl});
        end
    endtask

    function automatic vec_t mk(int e, logic v, logic [7:0] d, logic t, logic b,
                                logic [2:0] l);
        vec_t r;
        r.e    = e;
        r.v    = v;
        r.d    = d;
        r.txd  = t;
        r.busy = b;
        r.lvl  = l;
        return r;
    endfunction

    // Serial receiver for dut_a: detect the start bit, then sample mid-bit.
    logic       rx_active = 1'b0;
    int         rx_off    = 0;
    logic [7:0] rx_byte   = 8'h00;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (a_txd === 1'b0) begin
                rx_active = 1'b1;
                rx_off    = 0;
            end
        end else begin
            rx_off++;
            if (rx_off == 5) begin
                checkOutput("rx start bit", {31'b0, a_txd}, 32'd0);
            end else if ((rx_off >= 15) && (rx_off <= 85) && ((rx_off % 10) == 5)) begin
                rx_byte[(rx_off - 15) / 10] = a_txd;
            end else if (rx_off == 95) begin
                checkOutput("rx stop bit", {31'b0, a_txd}, 32'd1);
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        int t0;
        int acc[6];

        // 0xA5 LSB first: 1,0,1,0,0,1,0,1
        single_vecs.push_back(mk(0,   1'b1, 8'hA5, 1'b1, 1'b0, 3'd1));
        single_vecs.push_back(mk(1,   1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(10,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(11,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(20,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(21,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(31,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(41,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(51,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(61,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(71,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(80,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        single_vecs.push_back(mk(81,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(91,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(100, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(101, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        single_vecs.push_back(mk(102, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0));

        // Two stop bits: 0x7E (0,1,1,1,1,1,1,0) then 0x99 (1,0,0,1,1,0,0,1)
        stop2_vecs.push_back(mk(0,   1'b1, 8'h7E, 1'b1, 1'b0, 3'd1));
        stop2_vecs.push_back(mk(1,   1'b1, 8'h99, 1'b0, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(10,  1'b0, 8'h00, 1'b0, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(11,  1'b0, 8'h00, 1'b0, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(21,  1'b0, 8'h00, 1'b1, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(80,  1'b0, 8'h00, 1'b1, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(81,  1'b0, 8'h00, 1'b0, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(90,  1'b0, 8'h00, 1'b0, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(91,  1'b0, 8'h00, 1'b1, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(101, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(110, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1));
        stop2_vecs.push_back(mk(111, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        stop2_vecs.push_back(mk(121, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        stop2_vecs.push_back(mk(131, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0));
        stop2_vecs.push_back(mk(211, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        stop2_vecs.push_back(mk(220, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        stop2_vecs.push_back(mk(221, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0));
        stop2_vecs.push_back(mk(222, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0));

        // ---- reset ----
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset txd",   {31'b0, a_txd},   32'd1);
        checkOutput("reset busy",  {31'b0, a_busy},  32'd0);
        checkOutput("reset level", {29'b0, a_level}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset ready",   {31'b0, a_ready}, 32'd1);
        checkOutput("post-reset b ready", {31'b0, b_ready}, 32'd1);
        checkOutput("post-reset b txd",   {31'b0, b_txd},   32'd1);

        // ---- single byte 0xA5 ----
        $display("[TB] single byte");
        cur_vecs = single_vecs;
        run_table(1'b0, "single");
        wait_idle(500);
        exp_q.push_back(8'hA5);
        check_rx("single");

        // ---- back-to-back 0x00, 0xFF, 0x55 ----
        $display("[TB] back-to-back");
        applyStimulus(1'b0, 1'b1, 8'h00);
        wait_until(cyc + 1);
        t0 = cyc;
        checkOutput("b2b e0 level", {29'b0, a_level}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        wait_until(t0 + 1);
        checkOutput("b2b e1 level", {29'b0, a_level}, 32'd1);
        checkOutput("b2b e1 txd",   {31'b0, a_txd},   32'd0);
        applyStimulus(1'b0, 1'b1, 8'h55);
        wait_until(t0 + 2);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("b2b e2 level", {29'b0, a_level}, 32'd2);
        wait_until(t0 + 100);
        checkOutput("b2b e100 txd",   {31'b0, a_txd},   32'd1);
        checkOutput("b2b e100 level", {29'b0, a_level}, 32'd2);
        wait_until(t0 + 101);
        checkOutput("b2b e101 txd",   {31'b0, a_txd},   32'd0);
        checkOutput("b2b e101 level", {29'b0, a_level}, 32'd1);
        wait_until(t0 + 200);
        checkOutput("b2b e200 txd",   {31'b0, a_txd},   32'd1);
        wait_until(t0 + 201);
        checkOutput("b2b e201 txd",   {31'b0, a_txd},   32'd0);
        checkOutput("b2b e201 level", {29'b0, a_level}, 32'd0);
        wait_until(t0 + 301);
        checkOutput("b2b e301 busy",  {31'b0, a_busy},  32'd1);
        wait_until(t0 + 302);
        checkOutput("b2b e302 busy",  {31'b0, a_busy},  32'd0);
        wait_idle(500);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        check_rx("b2b");

        // ---- full FIFO, tx_valid held ----
        $display("[TB] full fifo");
        for (int i = 0; i < 6; i++) begin
            push_held(8'(i + 1), acc[i]);
            if (i == 4) begin
                checkOutput("full level", {29'b0, a_level}, 32'd4);
                checkOutput("full ready", {31'b0, a_ready}, 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("full refill level", {29'b0, a_level}, 32'd4);
        for (int i = 1; i < 6; i++) begin
            checkOutput($sformatf("full accept edge %0d", i + 1),
                        acc[i] - acc[0], (i == 5) ? 32'd102 : i);
        end
        wait_idle(1000);
        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
        check_rx("full");

        // ---- simultaneous push/pop, from IDLE and from final STOP ----
        $display("[TB] push with pop");
        applyStimulus(1'b0, 1'b1, 8'h11);
        wait_until(cyc + 1);
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 8'h22);
        wait_until(t0 + 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pp idle level", {29'b0, a_level}, 32'd1);
        wait_until(t0 + 149);
        applyStimulus(1'b0, 1'b1, 8'h44);
        wait_until(t0 + 150);
        applyStimulus(1'b0, 1'b0, 8'h00);
        wait_until(t0 + 200);
        checkOutput("pp e200 level", {29'b0, a_level}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'h55);
        wait_until(t0 + 201);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pp stop level", {29'b0, a_level}, 32'd1);
        checkOutput("pp stop txd",   {31'b0, a_txd},   32'd0);
        wait_idle(1000);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        check_rx("pp");

        // ---- reset during DATA bit 3 of 0x3C with two bytes queued ----
        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 8'h3C);
        wait_until(cyc + 1);
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, 8'hAA);
        wait_until(t0 + 1);
        applyStimulus(1'b0, 1'b1, 8'hBB);
        wait_until(t0 + 2);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rst queued level", {29'b0, a_level}, 32'd2);
        wait_until(t0 + 45);
        checkOutput("rst pre busy", {31'b0, a_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst txd",   {31'b0, a_txd},   32'd1);
        checkOutput("rst level", {29'b0, a_level}, 32'd0);
        checkOutput("rst busy",  {31'b0, a_busy},  32'd0);
        @(posedge clk);
        #1;
        wait_until(cyc + 2);
        rst_n = 1'b1;
        rx_q.delete();
        wait_until(cyc + 2);
        checkOutput("rst release txd",   {31'b0, a_txd},   32'd1);
        checkOutput("rst release ready", {31'b0, a_ready}, 32'd1);
        applyStimulus(1'b0, 1'b1, 8'h81);
        wait_until(cyc + 1);
        t0 = cyc;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rst push txd",   {31'b0, a_txd},   32'd1);
        checkOutput("rst push level", {29'b0, a_level}, 32'd1);
        wait_until(t0 + 1);
        checkOutput("rst start txd",  {31'b0, a_txd},   32'd0);
        checkOutput("rst start level", {29'b0, a_level}, 32'd0);
        wait_idle(500);
        exp_q.push_back(8'h81);
        check_rx("rst");

        // ---- two stop bits on dut_b ----
        $display("[TB] two stop bits");
        cur_vecs = stop2_vecs;
        run_table(1'b1, "stop2");
        wait_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
